// File: rtl/cnn_acc_pkg.sv
// ---------------------------------------------------------------------------
// cnn_acc_pkg
//   Shared definitions for the MAC-datapath front end.
//   - Default group size and field widths used by exp_max_collector.
//   - Collector state encoding (FILL / DRAIN).
//   - pp_pair_t: one (exponent, signed partial product) pair at the default
//     widths. Modules with overridden widths build an equivalent local struct.
// ---------------------------------------------------------------------------
package cnn_acc_pkg;

  localparam int N_PP_DEFAULT  = 8;
  localparam int EXP_W_DEFAULT = 5;
  localparam int PP_W_DEFAULT  = 5;

  // FILL collects a group, DRAIN replays it. The two phases never overlap.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [EXP_W_DEFAULT-1:0]       exp;
    logic signed [PP_W_DEFAULT-1:0] pp;
  } pp_pair_t;

endpackage : cnn_acc_pkg

// File: rtl/exp_max_cmp.sv
// ---------------------------------------------------------------------------
// exp_max_cmp
//   Combinational unsigned maximum of two exponents.
//
//   Optional behaviour (macro EXPMAX_ZERO_EXCLUDE_EN):
//     defined   - when excl_b is high, b does not take part and y = a.
//     undefined - excl_b is ignored; y = max(a, b) always.
//
// Ports:
//   a       in  EXP_W  current running maximum
//   b       in  EXP_W  candidate exponent
//   excl_b  in  1      candidate belongs to a zero partial product
//   y       out EXP_W  resulting maximum
// ---------------------------------------------------------------------------
module exp_max_cmp #(
  parameter int EXP_W = 5
) (
  input  logic [EXP_W-1:0] a,
  input  logic [EXP_W-1:0] b,
  input  logic             excl_b,
  output logic [EXP_W-1:0] y
);

  logic b_wins;

`ifdef EXPMAX_ZERO_EXCLUDE_EN
  // A zero product contributes nothing to the sum, so its exponent must not
  // widen the alignment shift of the other products.
  assign b_wins = (b > a) && !excl_b;
`else
  logic unused_excl_b;
  assign unused_excl_b = excl_b;
  assign b_wins        = (b > a);
`endif

  assign y = b_wins ? b : a;

endmodule : exp_max_cmp

// File: rtl/exp_max_collector.sv
// ---------------------------------------------------------------------------
// exp_max_collector
//   Buffers one group of N_PP (exponent, signed partial product) pairs while
//   tracking the running maximum exponent, then replays every pair in arrival
//   order together with the group maximum so the downstream alignment stage
//   can shift each product by (exp_max - exp).
//
//   Handshake semantics (both sides): a beat moves on a rising clk edge where
//   valid && ready. The producer holds data stable while valid && !ready; the
//   collector never drops a beat. in_ready and out_valid depend only on the
//   internal state and rst, never on the opposite side's valid/ready.
//
//   Phases: FILL accepts exactly N_PP pairs (gaps allowed), DRAIN emits
//   exactly N_PP pairs (backpressure allowed). out_last marks the final one.
//
//   Optional feature: define EXPMAX_ZERO_EXCLUDE_EN to keep pairs with
//   in_pp == 0 out of the maximum (they are still stored and replayed).
//
// Ports:
//   clk          in   1      clock
//   rst          in   1      synchronous active-high reset
//   in_valid     in   1      upstream pair valid
//   in_ready     out  1      collector accepts a pair (FILL, not in reset)
//   in_exp       in   EXP_W  exponent of incoming pair (unsigned, biased)
//   in_pp        in   PP_W   signed partial product of incoming pair
//   out_valid    out  1      replayed pair valid (DRAIN, not in reset)
//   out_ready    in   1      consumer ready
//   out_exp      out  EXP_W  exponent of replayed pair
//   out_exp_max  out  EXP_W  maximum exponent of the current group
//   out_pp       out  PP_W   replayed partial product, unmodified
//   out_last     out  1      final pair of the group
// ---------------------------------------------------------------------------
module exp_max_collector
  import cnn_acc_pkg::*;
#(
  parameter  int N_PP  = N_PP_DEFAULT,
  parameter  int EXP_W = EXP_W_DEFAULT,
  parameter  int PP_W  = PP_W_DEFAULT,
  localparam int CNT_W = $clog2(N_PP)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic signed [PP_W-1:0] in_pp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_exp,
  output logic [EXP_W-1:0]       out_exp_max,
  output logic signed [PP_W-1:0] out_pp,
  output logic                   out_last
);

  // Same layout as pp_pair_t, but following this instance's widths.
  typedef struct packed {
    logic [EXP_W-1:0]       exp;
    logic signed [PP_W-1:0] pp;
  } pair_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PP - 1);

  // ---------------------------------------------------------------------
  // State and storage. state_q is the observable FSM state.
  // ---------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] wr_cnt_q,  wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q,  rd_cnt_d;
  logic [EXP_W-1:0] run_max_q, run_max_d;
  logic [EXP_W-1:0] exp_max_q, exp_max_d;
  pair_t            pair_buf_q [N_PP];
  pair_t            pair_buf_d [N_PP];

  logic             accept;
  logic             xfer;
  logic             wr_last;
  logic             rd_last;
  logic [EXP_W-1:0] max_next;

  assign accept  = in_valid  && in_ready;
  assign xfer    = out_valid && out_ready;
  assign wr_last = (wr_cnt_q == CNT_LAST);
  assign rd_last = (rd_cnt_q == CNT_LAST);

  // max(run_max, in_exp). The same result is the new running maximum on an
  // ordinary accept and the latched group maximum on the final accept, so
  // the last pair of the group is always included.
  exp_max_cmp #(
    .EXP_W (EXP_W)
  ) u_max_cmp (
    .a      (run_max_q),
    .b      (in_exp),
    .excl_b (in_pp == '0),
    .y      (max_next)
  );

  // ---------------------------------------------------------------------
  // FSM process 1: state register (plus the datapath flops it governs).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      run_max_q <= '0;
      exp_max_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      run_max_q <= run_max_d;
      exp_max_q <= exp_max_d;
    end
  end

  // Buffer contents are don't-care after reset; only the counters matter.
  always_ff @(posedge clk) begin
    pair_buf_q <= pair_buf_d;
  end

  // ---------------------------------------------------------------------
  // FSM process 2: next state.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && wr_last) state_d = DRAIN;
      DRAIN:   if (xfer && rd_last)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM process 3: outputs. Gating with rst keeps both handshakes quiet
  // during the reset cycle whatever state the flops hold.
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready    = (state_q == FILL)  && !rst;
    out_valid   = (state_q == DRAIN) && !rst;
    out_last    = out_valid && rd_last;
    out_exp     = pair_buf_q[rd_cnt_q].exp;
    out_pp      = pair_buf_q[rd_cnt_q].pp;
    out_exp_max = exp_max_q;
  end

  // ---------------------------------------------------------------------
  // Datapath next values. accept can only be high in FILL and xfer only in
  // DRAIN, so the two halves never act in the same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    run_max_d  = run_max_q;
    exp_max_d  = exp_max_q;
    pair_buf_d = pair_buf_q;

    if (accept) begin
      pair_buf_d[wr_cnt_q] = {in_exp, in_pp};
      if (wr_last) begin
        exp_max_d = max_next;
        run_max_d = '0;
        wr_cnt_d  = '0;
      end else begin
        run_max_d = max_next;
        wr_cnt_d  = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (xfer) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + CNT_W'(1);
    end
  end

endmodule : exp_max_collector

// File: tb/tb_exp_max_collector.sv
// ---------------------------------------------------------------------------
// tb_exp_max_collector
//   Self-checking bench for exp_max_collector. A reference model groups the
//   accepted pairs, takes the maximum exponent over each completed group and
//   queues the expected replay words. Inputs are driven and outputs sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_exp_max_collector;

  localparam int N_PP  = 8;
  localparam int EXP_W = 5;
  localparam int PP_W  = 5;
  // Replay word: {exp, exp_max, pp, last}
  localparam int W     = 2 * EXP_W + PP_W + 1;

  // ---------------- clock / reset ----------------
  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W-1:0]       in_exp;
  logic signed [PP_W-1:0] in_pp;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W-1:0]       out_exp;
  logic [EXP_W-1:0]       out_exp_max;
  logic signed [PP_W-1:0] out_pp;
  logic                   out_last;

  always #5 clk = ~clk;

  exp_max_collector #(
    .N_PP  (N_PP),
    .EXP_W (EXP_W),
    .PP_W  (PP_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_exp      (in_exp),
    .in_pp       (in_pp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_exp     (out_exp),
    .out_exp_max (out_exp_max),
    .out_pp      (out_pp),
    .out_last    (out_last)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      got_q[$];
  int                grp_e[$];
  logic [PP_W-1:0]   grp_p[$];
  int                vectors = 0;
  int                miscompares = 0;
  int                stall_changes;
  int                inrdy_seen;
  bit                drain_timeout;

  // Group maximum from the whole group at once.
  task automatic model_push(input int e, input logic [PP_W-1:0] p);
    int mx;
    grp_e.push_back(e);
    grp_p.push_back(p);
    if (grp_e.size() == N_PP) begin
      mx = 0;
      for (int i = 0; i < N_PP; i++) begin
`ifdef EXPMAX_ZERO_EXCLUDE_EN
        if (grp_p[i] != '0 && grp_e[i] > mx) mx = grp_e[i];
`else
        if (grp_e[i] > mx) mx = grp_e[i];
`endif
      end
      for (int i = 0; i < N_PP; i++)
        exp_q.push_back({EXP_W'(grp_e[i]), EXP_W'(mx), grp_p[i], (i == N_PP - 1)});
      grp_e.delete();
      grp_p.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic push_pair(input int e, input int p, input int idle);
    int waited;
    in_valid = 1'b0;
    in_exp   = EXP_W'($urandom_range(0, 31));
    in_pp    = PP_W'($urandom_range(0, 31));
    repeat (idle) @(negedge clk);
    in_valid = 1'b1;
    in_exp   = EXP_W'(e);
    in_pp    = PP_W'(p);
    waited   = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_push(e, PP_W'(p));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,..., 2: random ready.
  task automatic drain_collect(input int mode, input int max_words);
    int           cyc;
    int           k;
    bit           have_prev;
    logic [W-1:0] prev;
    logic [W-1:0] cur;
    logic         rdy;
    got_q.delete();
    stall_changes = 0;
    inrdy_seen    = 0;
    drain_timeout = 1'b0;
    cyc = 0;
    k = 0;
    have_prev = 1'b0;
    prev = '0;
    while (got_q.size() < max_words && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      cur = {out_exp, out_exp_max, out_pp, out_last};
      if (out_valid) begin
        if (have_prev && cur !== prev) stall_changes++;
        if (in_ready) inrdy_seen++;
        k++;
        if (rdy) begin
          got_q.push_back(cur);
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev = cur;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    if (got_q.size() < max_words) drain_timeout = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_exp = '0;
    in_pp = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_exp_max !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b out_last=%b exp_max=%0d, required 0 0 0 0",
               in_ready, out_valid, out_last, out_exp_max);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_exp_max !== '0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b out_last=%b exp_max=%0d, required 1 0 0 0",
               in_ready, out_valid, out_last, out_exp_max);
    end
    @(negedge clk);
  endtask

  // Checks the drained words against the model and the handshake side effects.
  task automatic test_basic();
    int exps[N_PP] = '{2, 5, 3, 10, 1, 0, 7, 4};
    int pps[N_PP]  = '{-6, 7, 1, -1, 0, 3, 2, 5};
    logic [W-1:0] e;
    for (int i = 0; i < N_PP; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_fill_valid[%0d]: out_valid=%b, required 0", i, out_valid);
      end
      push_pair(exps[i], pps[i], 0);
    end
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
    end
    drain_collect(0, N_PP);
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL basic_word[%0d]: got %h, required %h", i, got_q[i], e);
      end
    end
    vectors++;
    if (drain_timeout || inrdy_seen != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_drain: timeout=%0b inrdy_seen=%0d out_valid=%b in_ready=%b, required 0 0 0 1",
               drain_timeout, inrdy_seen, out_valid, in_ready);
    end
  endtask

  task automatic test_max_last();
    logic [W-1:0] e;
    for (int i = 0; i < N_PP; i++) push_pair((i == N_PP - 1) ? 20 : 1, i + 1, 0);
    drain_collect(0, N_PP);
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL max_last_word[%0d]: got %h, required %h", i, got_q[i], e);
      end
    end
    vectors++;
    if (drain_timeout) begin
      miscompares++;
      $display("FAIL max_last_timeout: collected %0d, required %0d", got_q.size(), N_PP);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    for (int i = 0; i < N_PP; i++) push_pair($urandom_range(0, 31), $urandom_range(0, 31), 0);
    drain_collect(1, N_PP);
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL bp_word[%0d]: got %h, required %h", i, got_q[i], e);
      end
    end
    vectors++;
    if (drain_timeout || stall_changes != 0 || inrdy_seen != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: timeout=%0b stall_changes=%0d inrdy_seen=%0d out_valid=%b, required 0 0 0 0",
               drain_timeout, stall_changes, inrdy_seen, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    bit           seen_valid;
    // Mid-FILL: large exponents that must not leak into the next group.
    for (int i = 0; i < 4; i++) push_pair(30, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grp_e.delete();
    grp_p.delete();
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen_valid || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_fill_quiet: out_valid seen=%0b in_ready=%b, required 0 1", seen_valid, in_ready);
    end
    for (int i = 0; i < N_PP; i++) push_pair((i == 2) ? 9 : i, i - 3, 0);
    drain_collect(0, N_PP);
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL rst_next_word[%0d]: got %h, required %h", i, got_q[i], e);
      end
    end
    // Mid-DRAIN: take three words, then reset; the rest are discarded.
    for (int i = 0; i < N_PP; i++) push_pair($urandom_range(0, 31), $urandom_range(0, 31), 0);
    drain_collect(0, 3);
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL rst_drain_word[%0d]: got %h, required %h", i, got_q[i], e);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (seen_valid || in_ready !== 1'b1 || out_exp_max !== '0) begin
      miscompares++;
      $display("FAIL rst_drain_quiet: out_valid seen=%0b in_ready=%b exp_max=%0d, required 0 1 0",
               seen_valid, in_ready, out_exp_max);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < N_PP; i++)
        push_pair((g == 0) ? ((i == 5) ? 12 : i) : ((i == 1) ? 3 : (i % 3)), i, 0);
      drain_collect(0, N_PP);
      for (int i = 0; i < got_q.size(); i++) begin
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got_q[i] !== e) begin
          miscompares++;
          $display("FAIL b2b_word[g%0d][%0d]: got %h, required %h", g, i, got_q[i], e);
        end
      end
      // The next group's first pair is accepted on the very next edge.
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_turnaround[g%0d]: in_ready=%b out_valid=%b, required 1 0", g, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_zero_pp();
    logic [W-1:0] e;
    // Largest exponent sits on a zero product; then an all-zero group.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < N_PP; i++) begin
        if (g == 0) push_pair((i == 3) ? 25 : (i % 7), (i == 3) ? 0 : i + 1, 0);
        else        push_pair($urandom_range(1, 31), 0, 0);
      end
      drain_collect(0, N_PP);
      for (int i = 0; i < got_q.size(); i++) begin
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got_q[i] !== e) begin
          miscompares++;
          $display("FAIL zero_pp_word[g%0d][%0d]: got %h, required %h", g, i, got_q[i], e);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    int           p;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < N_PP; i++) begin
        p = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
        push_pair($urandom_range(0, 31), p, $urandom_range(0, 2));
      end
      drain_collect(2, N_PP);
      for (int i = 0; i < got_q.size(); i++) begin
        vectors++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        if (got_q[i] !== e) begin
          miscompares++;
          $display("FAIL rand_word[g%0d][%0d]: got %h, required %h", g, i, got_q[i], e);
        end
      end
      vectors++;
      if (drain_timeout || stall_changes != 0 || inrdy_seen != 0) begin
        miscompares++;
        $display("FAIL rand_drain[g%0d]: timeout=%0b stall_changes=%0d inrdy_seen=%0d, required 0 0 0",
                 g, drain_timeout, stall_changes, inrdy_seen);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL final_drain: leftover=%0d out_valid=%b, required 0 0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_max_last();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_zero_pp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_exp_max_collector

// File: doc/exp_max_collector.md
Name: exp_max_collector

Overview:
- Upstream stage of `alignment` in the MAC datapath.
- Buffers one group of N_PP (exponent, signed partial product) pairs and finds the group's maximum exponent.
- Replays each pair together with that exp_max, so `alignment` can shift every partial product by exp_max − exp before the adder tree.
- Two-phase FILL/DRAIN operation with valid/ready handshakes on both sides.

Parameters:
- N_PP, 8, partial products per group; power of two, ≥2.
- EXP_W, 5, exponent width (unsigned biased).
- PP_W, 5, signed partial-product width.
- CNT_W, $clog2(N_PP), index/counter width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream pair valid.
- in_ready  out  1  collector accepts a pair.
- in_exp  in  EXP_W  exponent of the incoming pair.
- in_pp  in  PP_W  signed partial product of the incoming pair.
- out_valid  out  1  replayed pair valid.
- out_ready  in  1  `alignment`-side consumer ready.
- out_exp  out  EXP_W  exponent of the replayed pair (to alignment.exp).
- out_exp_max  out  EXP_W  group maximum exponent (to alignment.exp_max).
- out_pp  out  PP_W  replayed partial product (to alignment.signed_pp).
- out_last  out  1  high with the final pair of a group.

Behaviour:
- Reset (clk edge with rst=1): state=FILL, wr_cnt=0, rd_cnt=0, run_max=0, exp_max_q=0, buffer contents don't-care. Outputs while rst is high and in the first cycle after it: in_ready=0 during rst, out_valid=0, out_last=0, out_exp_max=0.
- Accept/transfer rules: a pair is accepted on a rising edge with in_valid&in_ready; an output transfers on out_valid&out_ready.
- FILL:
  - in_ready=1 (when rst=0), out_valid=0.
  - On accept: buf[wr_cnt]<={in_exp,in_pp}; run_max<=max(run_max,in_exp), unsigned compare.
  - On accept with wr_cnt≠N_PP−1: wr_cnt++.
  - On accept with wr_cnt==N_PP−1: exp_max_q<=max(run_max,in_exp) (includes this final pair); run_max<=0; wr_cnt<=0; state<=DRAIN.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_exp/out_pp=buf[rd_cnt], out_exp_max=exp_max_q, out_last=(rd_cnt==N_PP−1).
  - On transfer: rd_cnt++; on the transfer with out_last=1: rd_cnt<=0, state<=FILL.
- Latency: first out_valid in the cycle after the N_PP-th input is accepted. Group throughput is 2·N_PP cycles minimum; no overlap of fill and drain.
- Backpressure: out_ready=0 holds all out_* stable; nothing is dropped.
- Input stalls: in_valid gaps during FILL are allowed; counters and run_max hold.
- Equal exponents: ties give the same max. exp_max==exp is legal and yields shift 0 downstream.
- in_pp is stored unmodified, sign intact; no arithmetic on pp.
- rst mid-FILL or mid-DRAIN: the partial group is discarded, returns to FILL with all counters cleared; no out_valid after reset until a full new group is accepted.
- out_exp_max is constant for all N_PP outputs of a group.

Optional Feature:
- Macro EXPMAX_ZERO_EXCLUDE_EN.
- Defined: a pair with in_pp==0 is stored and replayed but does not update run_max; a group of all zeros gives exp_max_q=0.
- Undefined: every pair participates in the max regardless of in_pp.

Decomposition:
- Shared package `cnn_acc_pkg`: EXP_W, PP_W, N_PP defaults; state enum {FILL, DRAIN}; typedef pp_pair_t {exp, pp}.
- Natural sub-module `exp_max_cmp`: combinational unsigned max of two EXP_W values, with a zero-exclude input gated by the macro. Reused by the running-max update and the final latch.

Test Plan:
- Basic group, N_PP=8: in_exp {2,5,3,10,1,0,7,4}, in_pp {−6,7,1,−1,0,3,2,5}, out_ready=1 → 8 outputs in order, out_exp_max=10 on all, out_last only on the 8th, in_ready=0 for 8 cycles.
- Max on last element: exps {1,1,1,1,1,1,1,20} → out_exp_max=20 (final pair included).
- Backpressure: out_ready toggles 1,0,0,1,… during DRAIN → outputs held stable while low; all 8 delivered exactly once; in_ready stays 0 until the last transfer.
- Mid-group reset: accept 4 pairs, assert rst 1 cycle → out_valid stays 0. A following full group with max 9 → out_exp_max=9, not contaminated by earlier exps.
- Back-to-back groups: group A max 12, group B max 3 → B reports 3 (run_max cleared), B's first pair accepted the cycle after A's out_last transfer.
- EXPMAX_ZERO_EXCLUDE_EN defined: pairs (exp 25, pp 0) plus others with max exp 6 → out_exp_max=6. Undefined → 25.
